// File: rtl/dma_sched_pkg.sv
// Shared types and constants for the DMA channel scheduler.
package dma_sched_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;

    localparam logic [NUM_CH-1:0] MASK_RST = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_TERM = 2'd3
    } state_e;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        return NUM_CH'(1) << ch;
    endfunction

endpackage

// File: rtl/dma_prio_encoder.sv
// Masked priority encoder; the rotation offset names the highest-priority channel.
module dma_prio_encoder
    import dma_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   rot,
    output logic              valid_c,
    output logic [CH_W-1:0]   idx_c
);

    logic [NUM_CH-1:0] elig;

    assign elig = req & ~mask;

    // Scan from rot upward, wrapping, and keep the first eligible channel.
    always_comb begin
        valid_c = 1'b0;
        idx_c   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!valid_c && elig[rot + CH_W'(i)]) begin
                valid_c = 1'b1;
                idx_c   = rot + CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/dma_channel_scheduler.sv
// Four-channel DMA request scheduler: arbitration, hold handshake, count and TC tracking.
// Optional build macro DMA_ROTATE_PRIORITY_EN enables rotating priority.
module dma_channel_scheduler
    import dma_sched_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] dreq,
    input  logic              hlda,
    input  logic              xfer_done,
    input  logic              mask_wr,
    input  logic [NUM_CH-1:0] mask_data,
    input  logic              cnt_wr,
    input  logic [CH_W-1:0]   cnt_ch,
    input  logic [CNT_W-1:0]  cnt_data,
    input  logic [NUM_CH-1:0] autoinit,
    input  logic              status_rd,
    output logic              hrq,
    output logic [NUM_CH-1:0] dack,
    output logic [CH_W-1:0]   ch_sel,
    output logic              tc,
    output logic [NUM_CH-1:0] tc_status,
    output logic [NUM_CH-1:0] mask,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
    logic              hrq_q, hrq_d;
    logic              tc_q, tc_d;
    logic              busy_q, busy_d;
    logic [NUM_CH-1:0] dack_q, dack_d;
    logic [NUM_CH-1:0] tc_status_q, tc_status_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  base_q [NUM_CH];
    logic [CNT_W-1:0]  base_d [NUM_CH];
    logic [CNT_W-1:0]  cur_q  [NUM_CH];
    logic [CNT_W-1:0]  cur_d  [NUM_CH];

    logic              prio_valid_c;
    logic [CH_W-1:0]   prio_idx_c;
    logic [CH_W-1:0]   rot_c;

    dma_prio_encoder u_prio (
        .req     (dreq),
        .mask    (mask_q),
        .rot     (rot_c),
        .valid_c (prio_valid_c),
        .idx_c   (prio_idx_c)
    );

`ifdef DMA_ROTATE_PRIORITY_EN
    logic [CH_W-1:0] rot_q, rot_d;

    // After servicing a channel, the next index up becomes highest priority.
    always_comb begin
        rot_d = rot_q;
        if ((state_q == ST_XFER || state_q == ST_TERM) && state_d == ST_IDLE) begin
            rot_d = ch_sel_q + CH_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rot_q <= '0;
        end else begin
            rot_q <= rot_d;
        end
    end

    assign rot_c = rot_q;
`else
    assign rot_c = '0;
`endif

    always_comb begin
        state_d     = state_q;
        ch_sel_d    = ch_sel_q;
        hrq_d       = hrq_q;
        dack_d      = dack_q;
        tc_d        = 1'b0;
        tc_status_d = status_rd ? '0 : tc_status_q;
        mask_d      = mask_wr ? mask_data : mask_q;
        base_d      = base_q;
        cur_d       = cur_q;

        // The serviced channel's counters belong to the FSM while busy.
        if (cnt_wr && !(busy_q && cnt_ch == ch_sel_q)) begin
            base_d[cnt_ch] = cnt_data;
            cur_d[cnt_ch]  = cnt_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (prio_valid_c) begin
                    ch_sel_d = prio_idx_c;
                    hrq_d    = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (hlda) begin
                    dack_d  = ch_onehot(ch_sel_q);
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (xfer_done) begin
                    // Decrement from zero wraps to all-ones and marks terminal count.
                    cur_d[ch_sel_q] = cur_q[ch_sel_q] - CNT_W'(1);
                    if (cur_q[ch_sel_q] == '0) begin
                        tc_d    = 1'b1;
                        state_d = ST_TERM;
                    end else if (!dreq[ch_sel_q] || mask_q[ch_sel_q]) begin
                        state_d = ST_IDLE;
                    end
                end
                if (!hlda) begin
                    tc_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_TERM: begin
                tc_status_d[ch_sel_q] = 1'b1;
                if (autoinit[ch_sel_q]) begin
                    cur_d[ch_sel_q] = base_q[ch_sel_q];
                end else begin
                    mask_d[ch_sel_q] = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) begin
            hrq_d  = 1'b0;
            dack_d = '0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            ch_sel_q    <= '0;
            hrq_q       <= 1'b0;
            tc_q        <= 1'b0;
            busy_q      <= 1'b0;
            dack_q      <= '0;
            tc_status_q <= '0;
            mask_q      <= MASK_RST;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                base_q[i] <= '0;
                cur_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            ch_sel_q    <= ch_sel_d;
            hrq_q       <= hrq_d;
            tc_q        <= tc_d;
            busy_q      <= busy_d;
            dack_q      <= dack_d;
            tc_status_q <= tc_status_d;
            mask_q      <= mask_d;
            base_q      <= base_d;
            cur_q       <= cur_d;
        end
    end

    assign hrq       = hrq_q;
    assign dack      = dack_q;
    assign ch_sel    = ch_sel_q;
    assign tc        = tc_q;
    assign tc_status = tc_status_q;
    assign mask      = mask_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Scoreboard bench for dma_channel_scheduler: grants and TC pulses are checked by a monitor.
module tb_dma_channel_scheduler;

    localparam int unsigned CNT_W = 16;
`ifdef DMA_ROTATE_PRIORITY_EN
    localparam int SECOND_CH = 3;
`else
    localparam int SECOND_CH = 1;
`endif

    logic             CLK;
    logic             RESET;
    logic [3:0]       dreq;
    logic             hlda;
    logic             xfer_done;
    logic             mask_wr;
    logic [3:0]       mask_data;
    logic             cnt_wr;
    logic [1:0]       cnt_ch;
    logic [CNT_W-1:0] cnt_data;
    logic [3:0]       autoinit;
    logic             status_rd;
    logic             hrq;
    logic [3:0]       dack;
    logic [1:0]       ch_sel;
    logic             tc;
    logic [3:0]       tc_status;
    logic [3:0]       mask;
    logic             busy;

    int n_total = 0;
    int n_bad   = 0;
    int grant_q[$];
    int tc_q[$];

    dma_channel_scheduler #(.CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .dreq      (dreq),
        .hlda      (hlda),
        .xfer_done (xfer_done),
        .mask_wr   (mask_wr),
        .mask_data (mask_data),
        .cnt_wr    (cnt_wr),
        .cnt_ch    (cnt_ch),
        .cnt_data  (cnt_data),
        .autoinit  (autoinit),
        .status_rd (status_rd),
        .hrq       (hrq),
        .dack      (dack),
        .ch_sel    (ch_sel),
        .tc        (tc),
        .tc_status (tc_status),
        .mask      (mask),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        cyc();
        cyc();
        RESET = 1'b0;
    endtask

    task automatic wr_cnt(input int ch, input int val);
        cnt_wr = 1'b1; cnt_ch = 2'(ch); cnt_data = CNT_W'(val);
        cyc();
        cnt_wr = 1'b0;
    endtask

    task automatic wr_mask(input int val);
        mask_wr = 1'b1; mask_data = 4'(val);
        cyc();
        mask_wr = 1'b0;
    endtask

    task automatic clr_status();
        status_rd = 1'b1;
        cyc();
        status_rd = 1'b0;
    endtask

    // Wait for hrq, hold one cycle, then acknowledge; the monitor checks the grant.
    task automatic grant(input int ch);
        int k = 0;
        while (!hrq && k < 20) begin
            cyc();
            k++;
        end
        chk("hrq_rise", int'(hrq), 1);
        chk("req_ch_sel", int'(ch_sel), ch);
        cyc();
        grant_q.push_back(ch);
        hlda = 1'b1;
        cyc();
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) cyc();
            xfer_done = 1'b1;
            cyc();
            xfer_done = 1'b0;
        end
    endtask

    // Only the final pulse may raise tc; an earlier one finds the TC queue empty.
    task automatic run_to_tc(input int n, input int ch);
        pulses(n - 1);
        if (n > 1) cyc();
        tc_q.push_back(ch);
        xfer_done = 1'b1;
        cyc();
        xfer_done = 1'b0;
        chk("tc_pulse", int'(tc), 1);
    endtask

    task automatic end_term();
        dreq = 4'b0000;
        cyc();
        hlda = 1'b0;
    endtask

    // Monitor: pops an expectation on every new grant and every TC pulse.
    initial begin
        logic [3:0] prev_dack;
        int e;
        prev_dack = 4'b0000;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                if (dack != 4'b0000 && prev_dack == 4'b0000) begin
                    if (grant_q.size() == 0) begin
                        chk("grant_unexpected", int'(dack), 0);
                    end else begin
                        e = grant_q.pop_front();
                        chk("grant_dack", int'(dack), 1 << e);
                        chk("grant_ch_sel", int'(ch_sel), e);
                    end
                end
                if (tc) begin
                    if (tc_q.size() == 0) begin
                        chk("tc_unexpected", int'(tc), 0);
                    end else begin
                        e = tc_q.pop_front();
                        chk("tc_ch_sel", int'(ch_sel), e);
                        chk("tc_dack", int'(dack), 1 << e);
                    end
                end
            end
            prev_dack = dack;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b1; dreq = '0; hlda = 1'b0; xfer_done = 1'b0;
        mask_wr = 1'b0; mask_data = '0; cnt_wr = 1'b0; cnt_ch = '0;
        cnt_data = '0; autoinit = '0; status_rd = 1'b0;
        cyc();
        cyc();
        chk("rst_hrq", int'(hrq), 0);
        chk("rst_dack", int'(dack), 0);
        chk("rst_ch_sel", int'(ch_sel), 0);
        chk("rst_tc", int'(tc), 0);
        chk("rst_tc_status", int'(tc_status), 0);
        chk("rst_mask", int'(mask), 15);
        chk("rst_busy", int'(busy), 0);
        RESET = 1'b0;

        // Basic transfer: count 2 on ch1 takes three xfer_done pulses.
        wr_cnt(1, 2);
        wr_mask(0);
        dreq = 4'b0010;
        grant(1);
        run_to_tc(3, 1);
        end_term();
        chk("basic_mask", int'(mask), 4'b0010);
        chk("basic_tc_status", int'(tc_status), 4'b0010);
        chk("basic_hrq", int'(hrq), 0);
        chk("basic_dack", int'(dack), 0);
        chk("basic_busy", int'(busy), 0);

        // Simultaneous requests, then an abort decides who is next.
        do_reset();
        wr_cnt(1, 1);
        wr_cnt(3, 0);
        wr_mask(0);
        dreq = 4'b1010;
        grant(1);
        pulses(1);
        chk("sim_no_tc", int'(tc), 0);
        hlda = 1'b0;
        cyc();
        chk("sim_abort_busy", int'(busy), 0);
        grant(SECOND_CH);
        run_to_tc(1, SECOND_CH);
        end_term();
        chk("sim_mask", int'(mask), 1 << SECOND_CH);

        // Autoinit: reload from base, mask untouched; idle xfer_done ignored.
        autoinit = 4'b0001;
        clr_status();
        wr_mask(0);
        wr_cnt(0, 1);
        dreq = 4'b0001;
        grant(0);
        run_to_tc(2, 0);
        end_term();
        chk("auto_mask", int'(mask), 0);
        chk("auto_tc_status", int'(tc_status), 4'b0001);
        xfer_done = 1'b1;
        cyc();
        xfer_done = 1'b0;
        dreq = 4'b0001;
        grant(0);
        run_to_tc(2, 0);
        end_term();
        autoinit = 4'b0000;

        // hlda drop after one transfer on count 5 leaves 4 remaining.
        clr_status();
        wr_cnt(2, 5);
        wr_mask(0);
        dreq = 4'b0100;
        grant(2);
        pulses(1);
        hlda = 1'b0;
        cyc();
        chk("abort_hrq", int'(hrq), 0);
        chk("abort_dack", int'(dack), 0);
        chk("abort_busy", int'(busy), 0);
        grant(2);
        wr_cnt(2, 0);
        wr_cnt(3, 7);
        run_to_tc(5, 2);
        end_term();
        chk("abort_mask", int'(mask), 4'b0100);
        chk("abort_tc_status", int'(tc_status), 4'b0100);

        // mask_wr coincident with TERM on ch0.
        clr_status();
        wr_mask(0);
        wr_cnt(0, 0);
        dreq = 4'b0001;
        grant(0);
        run_to_tc(1, 0);
        mask_wr = 1'b1;
        mask_data = 4'b0100;
        end_term();
        mask_wr = 1'b0;
        chk("coll_mask", int'(mask), 4'b0101);
        chk("coll_tc_status_pre", int'(tc_status), 4'b0001);

        // status_rd coincident with TC on ch2.
        wr_mask(0);
        wr_cnt(2, 0);
        dreq = 4'b0100;
        grant(2);
        run_to_tc(1, 2);
        status_rd = 1'b1;
        end_term();
        status_rd = 1'b0;
        chk("coll_tc_status", int'(tc_status), 4'b0100);

        // Asynchronous reset between edges in the middle of a transfer.
        wr_cnt(1, 3);
        wr_mask(0);
        dreq = 4'b0010;
        grant(1);
        pulses(1);
        #2 RESET = 1'b1;
        #1;
        chk("async_hrq", int'(hrq), 0);
        chk("async_dack", int'(dack), 0);
        chk("async_mask", int'(mask), 15);
        chk("async_busy", int'(busy), 0);
        chk("async_tc_status", int'(tc_status), 0);
        hlda = 1'b0;
        cyc();
        RESET = 1'b0;
        wr_mask(0);
        grant(1);
        run_to_tc(1, 1);
        end_term();
        chk("post_rst_tc_status", int'(tc_status), 4'b0010);

        cyc();
        chk("grant_queue_empty", grant_q.size(), 0);
        chk("tc_queue_empty", tc_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
